// File: rtl/lat_fifo_pkg.sv
// Shared helpers for the latency-compensating FIFO.
//   clog2p1      : width of a counter that must hold the value DEPTH itself
//                  (occupancy and credit counters), i.e. $clog2(n)+1.
//   params_legal : parameter legality test used by the elaboration checks
//                  in latency_fifo (W 1..512, DEPTH power of two 2..256,
//                  LAT 0..64).
package lat_fifo_pkg;

    function automatic int clog2p1(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic bit params_legal(input int w, input int depth, input int lat);
        return (w >= 1) && (w <= 512) &&
               (depth >= 2) && (depth <= 256) && ((depth & (depth - 1)) == 0) &&
               (lat >= 0) && (lat <= 64);
    endfunction

endpackage

// File: rtl/latency_fifo_mem.sv
// Storage for latency_fifo: DEPTH x W register array.
//   clk   : clock, write on rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read, first-word fall-through)
//   rdata : data at raddr
// Contents are deliberately not reset; the control logic masks stale
// entries through out_valid.
module latency_fifo_mem
    import lat_fifo_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [clog2p1(DEPTH)-2:0]     waddr,
    input  logic [W-1:0]                  wdata,
    input  logic [clog2p1(DEPTH)-2:0]     raddr,
    output logic [W-1:0]                  rdata
);

    logic [W-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/latency_fifo.sv
// Latency-compensating FIFO sitting behind a fixed-delay upstream pipeline.
// Upstream launches an item only while it holds a credit (issue_ready); the
// item returns LAT cycles later on in_valid/in_data and is queued here.
// Credits cover in-flight items plus queued items, so with a well-behaved
// upstream the FIFO can never overflow; if it does, overflow latches.
//   clk         : clock
//   rst_n       : asynchronous active-low reset
//   issue_valid : upstream launches an item this cycle
//   issue_ready : credit available (reserved < DEPTH)
//   in_valid    : item returning from the pipeline
//   in_data     : returning item data
//   out_valid   : FIFO head valid (registered state only)
//   out_ready   : downstream accepts the head
//   out_data    : FIFO head data
//   count       : occupancy
//   overflow    : sticky, an item arrived into a full FIFO and was dropped
module latency_fifo
    import lat_fifo_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int LAT   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    input  logic                          in_valid,
    input  logic [W-1:0]                  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [W-1:0]                  out_data,
    output logic [clog2p1(DEPTH)-1:0]     count,
    output logic                          overflow
);

    localparam int CW = clog2p1(DEPTH);
    localparam int AW = CW - 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // LAT only documents the upstream pipeline; it is range-checked here.
    generate
        if (!params_legal(W, DEPTH, LAT)) begin : g_bad_params
            $error("latency_fifo: illegal parameters W=%0d DEPTH=%0d LAT=%0d", W, DEPTH, LAT);
        end
    endgenerate

    logic [AW-1:0] wr_ptr_reg,   wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg,   rd_ptr_next;
    logic [CW-1:0] count_reg,    count_next;
    logic [CW-1:0] reserved_reg, reserved_next;
    logic          overflow_reg, overflow_next;

    logic issue_fire;
    logic pop;
    logic push;

    always_comb begin
        issue_fire    = issue_valid && issue_ready;
        pop           = out_valid && out_ready;
        // A pop frees the slot this cycle, so a full FIFO still accepts.
        push          = in_valid && ((count_reg < DEPTH_C) || pop);

        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        reserved_next = reserved_reg;
        overflow_next = overflow_reg | (in_valid && !push);

        // Pointers are AW bits wide and DEPTH is a power of two, so the
        // natural roll-over is the modulo-DEPTH wrap.
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase

        // Credits return on pop. The floor at zero only matters when items
        // are injected without a credit; it keeps issue_ready from latching
        // low through a wrap of the counter.
        case ({issue_fire, pop})
            2'b10:   reserved_next = reserved_reg + CW'(1);
            2'b01:   reserved_next = (reserved_reg != '0) ? reserved_reg - CW'(1) : reserved_reg;
            default: reserved_next = reserved_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            reserved_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            reserved_reg <= reserved_next;
            overflow_reg <= overflow_next;
        end
    end

    latency_fifo_mem #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata (in_data),
        .raddr (rd_ptr_reg),
        .rdata (out_data)
    );

    // No look-ahead on a same-cycle pop: the credit returns a cycle later.
    assign issue_ready = (reserved_reg < DEPTH_C);
    assign out_valid   = (count_reg != '0);
    assign count       = count_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_latency_fifo.sv
// Directed bench for latency_fifo (W=8, DEPTH=4, LAT=3). A 3-stage
// fixed-delay model stands in for the upstream pipeline; force_v/force_d
// inject items on in_* directly, bypassing the credit scheme.
module tb_latency_fifo;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         issue_valid;
    logic         issue_ready;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   count;
    logic         overflow;

    logic [W-1:0] issue_data;
    logic         force_v;
    logic [W-1:0] force_d;
    logic         pipe_v [LAT];
    logic [W-1:0] pipe_d [LAT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    latency_fifo #(.W(W), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .overflow    (overflow)
    );

    // Fixed-delay upstream model, reset together with the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= issue_valid && issue_ready;
            pipe_d[0] <= issue_data;
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign in_valid = pipe_v[LAT-1] | force_v;
    assign in_data  = force_v ? force_d : pipe_d[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tbl [8];
        logic [7:0] pid;
        logic       piv;
        logic       acc;
        int         idx;
        int         exp_out;

        tbl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        rst_n       = 1'b1;
        issue_valid = 1'b0;
        issue_data  = '0;
        force_v     = 1'b0;
        force_d     = '0;
        out_ready   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid",   out_valid,   0);
        chk("rst_count",       count,       0);
        chk("rst_overflow",    overflow,    0);
        chk("rst_issue_ready", issue_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;

        // Credit stall: issue every cycle, no downstream acceptance.
        idx = 0;
        issue_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue_data = tbl[idx];
            acc = issue_valid && issue_ready;
            tick();
            if (acc) idx++;
            if (i == 3) begin
                chk("stall_ready_low", issue_ready, 0);
                chk("stall_first_out", out_data,    8'h11);
                chk("stall_count1",    count,       1);
            end
        end
        issue_valid = 1'b0;
        chk("stall_issued",   idx,       4);
        chk("stall_count4",   count,     4);
        chk("stall_head",     out_data,  8'h11);
        chk("stall_overflow", overflow,  0);

        // Full push+pop at count==4.
        force_v = 1'b1; force_d = 8'h55; out_ready = 1'b1;
        chk("fpp_head", out_data, 8'h11);
        tick();
        force_v = 1'b0; out_ready = 1'b0;
        chk("fpp_count",    count,       4);
        chk("fpp_head2",    out_data,    8'h22);
        chk("fpp_overflow", overflow,    0);
        chk("fpp_credit",   issue_ready, 1);
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            chk("fpp_order", out_data, 32'(tbl[i]));
            tick();
        end
        out_ready = 1'b0;
        chk("fpp_last",  out_data, 8'h55);
        chk("fpp_count1", count,   1);
        do_reset();

        // Overflow: fill by injection, then inject 0xAA into a full FIFO.
        for (int i = 0; i < 4; i++) begin
            force_v = 1'b1; force_d = 8'hA1 + 8'(i);
            tick();
        end
        chk("ovf_count4", count,    4);
        chk("ovf_pre",    overflow, 0);
        force_d = 8'hAA;
        tick();
        force_v = 1'b0;
        chk("ovf_set",    overflow, 1);
        chk("ovf_count",  count,    4);
        tick();
        chk("ovf_hold",   overflow, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain", out_data, 32'(8'hA1 + 8'(i)));
            tick();
        end
        out_ready = 1'b0;
        chk("ovf_no_aa",   out_valid, 0);
        chk("ovf_hold2",   overflow,  1);
        do_reset();
        chk("ovf_cleared", overflow,  0);

        // Streaming 0..19 with out_ready high.
        out_ready = 1'b1;
        idx = 0;
        exp_out = 0;
        for (int cyc = 0; cyc < 200 && exp_out < 20; cyc++) begin
            issue_valid = (idx < 20);
            issue_data  = idx[7:0];
            acc = issue_valid && issue_ready;
            piv = in_valid;
            pid = in_data;
            tick();
            if (acc) idx++;
            if (piv) begin
                chk("stream_lat_valid", out_valid, 1);
                chk("stream_lat_data",  out_data,  pid);
            end
            if (out_valid) begin
                chk("stream_order", out_data, exp_out);
                exp_out++;
            end
            chk("stream_credit_bound", (count <= 3'd1) ? 1 : 0, 1);
        end
        issue_valid = 1'b0;
        chk("stream_total", exp_out, 20);
        tick();
        chk("stream_empty", count, 0);
        out_ready = 1'b0;
        do_reset();

        // Backpressure hold: out_ready 1,0,0,1.
        for (int i = 0; i < 3; i++) begin
            force_v = 1'b1; force_d = 8'h61 + 8'(i);
            tick();
        end
        force_v = 1'b0;
        out_ready = 1'b1;
        chk("bp_head0", out_data, 8'h61);
        tick();
        out_ready = 1'b0;
        chk("bp_hold_a", out_data, 8'h62);
        tick();
        chk("bp_hold_b", out_data, 8'h62);
        tick();
        chk("bp_hold_c", out_data, 8'h62);
        chk("bp_count2", count,    2);
        out_ready = 1'b1;
        tick();
        chk("bp_next",   out_data, 8'h63);
        chk("bp_count1", count,    1);
        tick();
        out_ready = 1'b0;
        chk("bp_empty",  out_valid, 0);
        do_reset();

        // Reset mid-stream: count==3, overflow set, 2 items in flight.
        for (int i = 0; i < 5; i++) begin
            force_v = 1'b1; force_d = 8'hC1 + 8'(i);
            tick();
        end
        force_v = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        issue_valid = 1'b1;
        issue_data = 8'hD1;
        tick();
        issue_data = 8'hD2;
        tick();
        issue_valid = 1'b0;
        chk("mid_count3",   count,    3);
        chk("mid_overflow", overflow, 1);
        chk("mid_inflight", (pipe_v[0] && pipe_v[1]) ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    out_valid,   0);
        chk("mid_rst_count",    count,       0);
        chk("mid_rst_overflow", overflow,    0);
        chk("mid_rst_ready",    issue_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_no_stale", out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/latency_fifo.md
LATENCY_FIFO -- requirements
Module: latency_fifo

Interface
REQ-001 Parameter W, default 8: data width, 1..512.
REQ-002 Parameter DEPTH, default 4: FIFO entries, a power of two, 2..256.
REQ-003 Parameter LAT, default 3: fixed latency of the upstream fixed-delay pipeline, 0..64, informational only.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 issue_valid  input  1  upstream launches one item into the fixed-delay pipeline this cycle.
REQ-007 issue_ready  output  1  a credit is available; upstream SHALL launch only while it is high.
REQ-008 in_valid  input  1  item returning from the fixed-delay pipeline.
REQ-009 in_data  input  W  returning item data.
REQ-010 out_valid  output  1  FIFO head is valid.
REQ-011 out_ready  input  1  downstream accepts the head.
REQ-012 out_data  output  W  FIFO head data.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 overflow  output  1  sticky error flag.

Function
REQ-015 reserved counter, width $clog2(DEPTH)+1, SHALL equal in-flight items plus occupancy.
- +1 on issue_valid&&issue_ready.
- -1 on pop (out_valid&&out_ready).
- Issue and pop in the same cycle leave it unchanged.
REQ-016 issue_ready SHALL be combinational: (reserved < DEPTH); it does not look ahead on the current-cycle pop.
REQ-017 issue_valid while issue_ready is low SHALL be ignored and leave reserved unchanged.
REQ-018 Push condition: in_valid && (count<DEPTH || pop).
- in_data is written at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-019 in_valid while count==DEPTH and no pop SHALL drop the data and set overflow; overflow holds until reset.
REQ-020 Pop SHALL advance rd_ptr modulo DEPTH.
REQ-021 out_valid SHALL equal (count!=0), registered state only.
- out_data is the entry at rd_ptr (first-word fall-through).
- Write-to-out_valid latency is 1 cycle.
- No combinational path from in_* to out_*.
REQ-022 Simultaneous push and pop SHALL keep count unchanged, including at count==DEPTH and count==1.
REQ-023 Push into an empty FIFO with out_ready high SHALL be presented next cycle; no same-cycle bypass.
REQ-024 out_data SHALL hold stable while out_valid&&!out_ready.
REQ-025 Pointers SHALL wrap at DEPTH with no lost or duplicated entries.

Reset
REQ-026 On rst_n low the block SHALL immediately clear:
- wr_ptr, rd_ptr, count, reserved, overflow to 0;
- out_valid to 0;
- issue_ready to 1.
REQ-027 Storage contents are not reset; out_data is don't-care while out_valid==0.
REQ-028 Reset mid-operation SHALL discard all queued and in-flight accounting.
- in_valid arriving after reset release from pre-reset issues is counted as a push (upstream pipeline is reset together).

Structure
REQ-029 A shared package lat_fifo_pkg SHALL hold:
- the pointer/count width function clog2-plus-one;
- the parameter legality checks (elaboration assertions).
REQ-030 Storage SHALL be a sub-module latency_fifo_mem (DEPTH x W register array, one write port, one async read port).
- Control, credit counter and flags stay in latency_fifo.
REQ-031 Target size 150-300 RTL lines; no other sub-modules.

Verification (W=8, DEPTH=4, LAT=3, fixed-delay model in bench)
REQ-032 Credit stall:
- Stimulus: issue every cycle with out_ready=0.
- Response: issue_ready low after 4 issues; 4 items 0x11..0x44 appear on out_data in order; count==4; overflow==0.
REQ-033 Full push+pop:
- Stimulus: at count==4, one cycle with in_valid=1 (forced, data 0x55) and out_ready=1.
- Response: 0x11 popped; count stays 4; 0x55 queued last; overflow==0.
REQ-034 Overflow:
- Stimulus: at count==4, out_ready=0, force in_valid=1 with 0xAA.
- Response: overflow rises next cycle and holds; 0xAA never emitted.
REQ-035 Streaming wrap:
- Stimulus: issue 20 items 0..19, out_ready=1 throughout.
- Response: outputs 0..19 in order, each 1 cycle after in_valid; pointers wrap 5 times; reserved never exceeds 4.
REQ-036 Backpressure hold:
- Stimulus: out_ready toggles 1,0,0,1.
- Response: out_data stable during the 0 cycles; no drop or duplicate.
REQ-037 Reset mid-stream:
- Stimulus: rst_n low for 2 cycles with count==3 and 2 items in flight.
- Response: out_valid, count, overflow go to 0 immediately; issue_ready 1; no stale item emitted afterwards.
